// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM states and flag bundle.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic zero;
        logic carry;
        logic neg;
        logic ovf;
    } flags_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add unsigned multiplier: one partial product per step, WIDTH steps per product.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               step,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] addend;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;

    // product is the accumulator value after the current step, so the final
    // step's sum can be captured by the parent on the same edge
    assign addend  = mplier[0] ? mcand : '0;
    assign product = acc + addend;
    assign done    = step && (cnt == CW'(WIDTH - 1));

    // Operand and accumulator registers; reloaded on every start
    always_ff @(posedge clk) begin
        if (start) begin
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
        end else if (step) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

    // Iteration counter; reset aborts a product in progress
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= '0;
        end else if (step) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered multi-operation ALU with valid/ready handshakes and a sequential multiplier.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             neg,
    output logic             ovf
);

    localparam int SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t                 state;
    state_t                 state_nx;
    logic                   in_ready_q;
    logic                   accept;
    logic                   mul_start;
    logic                   mul_done;
    logic [2*WIDTH-1:0]     mul_prod;

    logic [WIDTH:0]         sum;
    logic [WIDTH:0]         diff;
    logic [WIDTH:0]         shl_ext;
    logic [SW-1:0]          amt;
    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    logic [WIDTH-1:0]       res_nx;
    logic                   c_nx;
    logic                   v_nx;

    logic [WIDTH-1:0]       res_q;
    flags_t                 flags_q;

    function automatic flags_t make_flags(input logic [WIDTH-1:0] r,
                                          input logic c,
                                          input logic v);
        flags_t f;
        f.zero  = (r == '0);
        f.carry = c;
        f.neg   = r[WIDTH-1];
        f.ovf   = v;
        return f;
    endfunction

    assign accept    = in_valid && in_ready_q;
    assign mul_start = accept && (op == OP_MUL);
    assign in_ready  = in_ready_q;
    assign out_valid = (state == ST_DONE);

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .step    (state == ST_BUSY),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_prod)
    );

    // Single-cycle op mux; bit WIDTH of the shifted value is the last bit shifted out
    always_comb begin
        sum     = {1'b0, a} + {1'b0, b};
        diff    = {1'b0, a} - {1'b0, b};
        amt     = b[SW-1:0];
        shl_ext = {1'b0, a} << amt;
        a_s     = a;
        b_s     = b;
        res_nx  = '0;
        c_nx    = 1'b0;
        v_nx    = 1'b0;
        case (op)
            OP_ADD: begin
                res_nx = sum[WIDTH-1:0];
                c_nx   = sum[WIDTH];
                v_nx   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                res_nx = diff[WIDTH-1:0];
                c_nx   = diff[WIDTH];
                v_nx   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  res_nx = a & b;
            OP_OR:   res_nx = a | b;
            OP_XOR:  res_nx = a ^ b;
            OP_SLT:  res_nx = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
            OP_SHL: begin
                res_nx = shl_ext[WIDTH-1:0];
                c_nx   = shl_ext[WIDTH];
            end
            default: res_nx = '0;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // FSM next-state decode
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (accept) state_nx = (op == OP_MUL) ? ST_BUSY : ST_DONE;
            ST_BUSY: if (mul_done) state_nx = ST_DONE;
            ST_DONE: if (out_ready) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // in_ready is registered so it stays low through reset and has no input path
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_ready_q <= 1'b0;
        end else begin
            in_ready_q <= (state_nx == ST_IDLE);
        end
    end

    // Result and flag registers; held while waiting for out_ready
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_q   <= '0;
            flags_q <= '0;
        end else if (accept && (op != OP_MUL)) begin
            res_q   <= res_nx;
            flags_q <= make_flags(res_nx, c_nx, v_nx);
        end else if (mul_done) begin
            res_q   <= mul_prod[WIDTH-1:0];
            flags_q <= make_flags(mul_prod[WIDTH-1:0], |mul_prod[2*WIDTH-1:WIDTH], 1'b0);
        end
    end

    assign result = res_q;
    assign zero   = flags_q.zero;
    assign carry  = flags_q.carry;
    assign neg    = flags_q.neg;
    assign ovf    = flags_q.ovf;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=8) with a scoreboard of expected results.
module tb_alu_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [2:0]   op = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] result;
    logic         zero;
    logic         carry;
    logic         neg;
    logic         ovf;

    typedef struct packed {
        logic [W-1:0] res;
        logic [3:0]   flg;
        logic [7:0]   lat;
    } exp_t;

    typedef struct packed {
        logic [2:0]   op;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] res;
        logic [3:0]   flg;
    } vec_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .carry     (carry),
        .neg       (neg),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference model, flags packed as {zero, carry, neg, ovf}
    function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t           e;
        logic [W:0]     s;
        logic [2*W-1:0] p;
        logic [W-1:0]   r;
        logic           c;
        logic           v;
        int             amt;
        r = '0; c = 1'b0; v = 1'b0;
        case (o)
            3'd0: begin
                s = x + y;
                r = s[W-1:0];
                c = s[W];
                v = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
            end
            3'd1: begin
                r = x - y;
                c = (x < y);
                v = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
            end
            3'd2: r = x & y;
            3'd3: r = x | y;
            3'd4: r = x ^ y;
            3'd5: r = {{(W-1){1'b0}}, ($signed(x) < $signed(y))};
            3'd6: begin
                amt = int'(y[2:0]);
                r = x << amt;
                c = (amt == 0) ? 1'b0 : x[W-amt];
            end
            default: begin
                p = x * y;
                r = p[W-1:0];
                c = |p[2*W-1:W];
            end
        endcase
        e.res = r;
        e.flg = {(r == '0), c, r[W-1], v};
        e.lat = (o == 3'd7) ? 8'(W + 1) : 8'd1;
        return e;
    endfunction

    task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input exp_t e);
        @(negedge clk);
        in_valid = 1'b1;
        op = o;
        a = x;
        b = y;
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op = 3'($urandom);
        a = W'($urandom);
        b = W'($urandom);
    endtask

    task automatic wait_out(output logic [W-1:0] r, output logic [3:0] f, output int lat);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
        r = result;
        f = {zero, carry, neg, ovf};
    endtask

    task automatic release_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, out_valid, result, zero, carry, neg, ovf} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%b vld=%b res=%h flags=%b%b%b%b want all 0",
                     in_ready, out_valid, result, zero, carry, neg, ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready got %b want 1", in_ready);
        end
    endtask

    task automatic test_single_ops();
        vec_t         tv[11];
        exp_t         e;
        exp_t         got;
        logic [W-1:0] r;
        logic [3:0]   f;
        int           lat;
        tv[0]  = '{3'd0, 8'hC8, 8'h64, 8'h2C, 4'b0100};
        tv[1]  = '{3'd0, 8'h7F, 8'h01, 8'h80, 4'b0011};
        tv[2]  = '{3'd1, 8'h05, 8'h07, 8'hFE, 4'b0110};
        tv[3]  = '{3'd5, 8'hFF, 8'h01, 8'h01, 4'b0000};
        tv[4]  = '{3'd6, 8'h81, 8'h01, 8'h02, 4'b0100};
        tv[5]  = '{3'd6, 8'h81, 8'h08, 8'h81, 4'b0010};
        tv[6]  = '{3'd4, 8'h5A, 8'h5A, 8'h00, 4'b1000};
        tv[7]  = '{3'd2, 8'hF0, 8'h3C, 8'h30, 4'b0000};
        tv[8]  = '{3'd3, 8'h0F, 8'hF0, 8'hFF, 4'b0010};
        tv[9]  = '{3'd1, 8'h80, 8'h01, 8'h7F, 4'b0001};
        tv[10] = '{3'd6, 8'h03, 8'h07, 8'h80, 4'b0110};
        for (int i = 0; i < 11; i++) begin
            e.res = tv[i].res;
            e.flg = tv[i].flg;
            e.lat = 8'd1;
            issue(tv[i].op, tv[i].x, tv[i].y, e);
            wait_out(r, f, lat);
            release_out();
            got = sb.pop_front();
            checks++;
            if (r !== got.res || f !== got.flg || lat !== int'(got.lat)) begin
                errors++;
                $display("FAIL single_op[%0d] got res=%h flags=%b lat=%0d want res=%h flags=%b lat=%0d",
                         i, r, f, lat, got.res, got.flg, got.lat);
            end
        end
    endtask

    task automatic test_mul();
        vec_t         tv[3];
        exp_t         e;
        exp_t         got;
        logic [W-1:0] r;
        logic [3:0]   f;
        int           lat;
        tv[0] = '{3'd7, 8'h0F, 8'h11, 8'hFF, 4'b0010};
        tv[1] = '{3'd7, 8'h10, 8'h10, 8'h00, 4'b1100};
        tv[2] = '{3'd7, 8'hFF, 8'hFF, 8'h01, 4'b0100};
        for (int i = 0; i < 3; i++) begin
            e.res = tv[i].res;
            e.flg = tv[i].flg;
            e.lat = 8'd9;
            issue(tv[i].op, tv[i].x, tv[i].y, e);
            wait_out(r, f, lat);
            release_out();
            got = sb.pop_front();
            checks++;
            if (r !== got.res || f !== got.flg || lat !== int'(got.lat)) begin
                errors++;
                $display("FAIL mul[%0d] got res=%h flags=%b lat=%0d want res=%h flags=%b lat=%0d",
                         i, r, f, lat, got.res, got.flg, got.lat);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]   o;
        logic [W-1:0] x;
        logic [W-1:0] y;
        exp_t         got;
        logic [W-1:0] r;
        logic [3:0]   f;
        int           lat;
        for (int i = 0; i < 16; i++) begin
            o = 3'($urandom_range(0, 7));
            x = W'($urandom);
            y = W'($urandom);
            issue(o, x, y, model(o, x, y));
            wait_out(r, f, lat);
            release_out();
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL b2b_ready[%0d] got rdy=%b vld=%b want rdy=1 vld=0", i, in_ready, out_valid);
            end
            got = sb.pop_front();
            checks++;
            if (r !== got.res || f !== got.flg || lat !== int'(got.lat)) begin
                errors++;
                $display("FAIL b2b[%0d] op=%0d a=%h b=%h got res=%h flags=%b lat=%0d want res=%h flags=%b lat=%0d",
                         i, o, x, y, r, f, lat, got.res, got.flg, got.lat);
            end
        end
    endtask

    task automatic test_backpressure();
        exp_t         e;
        exp_t         got;
        logic [W-1:0] r;
        logic [3:0]   f;
        int           lat;
        e.res = 8'h80;
        e.flg = 4'b0011;
        e.lat = 8'd1;
        issue(3'd0, 8'h7F, 8'h01, e);
        wait_out(r, f, lat);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = ~in_valid;
            op = 3'($urandom);
            a = W'($urandom);
            b = W'($urandom);
            @(posedge clk);
            #1;
            checks++;
            if (result !== r || {zero, carry, neg, ovf} !== f || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL backpressure[%0d] got res=%h flags=%b rdy=%b vld=%b want res=%h flags=%b rdy=0 vld=1",
                         i, result, {zero, carry, neg, ovf}, in_ready, out_valid, r, f);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        release_out();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_release got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_no_capture got vld=%b want 0", out_valid);
        end
        got = sb.pop_front();
        checks++;
        if (r !== got.res || f !== got.flg || lat !== int'(got.lat)) begin
            errors++;
            $display("FAIL backpressure_result got res=%h flags=%b lat=%0d want res=%h flags=%b lat=%0d",
                     r, f, lat, got.res, got.flg, got.lat);
        end
    endtask

    task automatic test_reset_mid_mul();
        exp_t         e;
        exp_t         got;
        logic [W-1:0] r;
        logic [3:0]   f;
        int           lat;
        @(negedge clk);
        in_valid = 1'b1;
        op = 3'd7;
        a = 8'hFF;
        b = 8'hFF;
        @(posedge clk);
        #1;
        // in_valid stays high in BUSY with a different bundle; it must be ignored
        op = 3'd0;
        a = 8'h11;
        b = 8'h22;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL busy_handshake got rdy=%b vld=%b want rdy=0 vld=0", in_ready, out_valid);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({in_ready, out_valid, result, zero, carry, neg, ovf} !== '0) begin
            errors++;
            $display("FAIL mid_mul_reset got rdy=%b vld=%b res=%h flags=%b%b%b%b want all 0",
                     in_ready, out_valid, result, zero, carry, neg, ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_mul_release got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
        end
        e.res = 8'h03;
        e.flg = 4'b0000;
        e.lat = 8'd1;
        issue(3'd0, 8'h01, 8'h02, e);
        wait_out(r, f, lat);
        release_out();
        got = sb.pop_front();
        checks++;
        if (r !== got.res || f !== got.flg || lat !== int'(got.lat)) begin
            errors++;
            $display("FAIL post_reset_add got res=%h flags=%b lat=%0d want res=%h flags=%b lat=%0d",
                     r, f, lat, got.res, got.flg, got.lat);
        end
    endtask

    initial begin
        test_reset();
        test_single_ops();
        test_mul();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_mul();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got %0d want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered, multi-operation ALU; the next-generation arithmetic unit for the datapath. Extends the earlier combinational add/AND unit with WIDTH-bit operands, an 8-entry opcode set, a full flag set, a multi-cycle shift-add multiplier and valid/ready handshakes on both sides. It sits between operand issue logic and the result writeback stage, one operation in flight at a time.

## Interface
- WIDTH, 8, operand/result width; legal values 4 to 32.
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operand/opcode bundle valid.
- in_ready  output  1  block can accept a bundle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- op  input  3  opcode (see Operation).
- out_valid  output  1  result/flags valid.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  registered result.
- zero  output  1  result == 0.
- carry  output  1  carry/borrow/shift-out/mul-overflow (per op).
- neg  output  1  result[WIDTH-1].
- ovf  output  1  signed overflow (ADD/SUB only).

## Operation
- Opcodes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT, 110 SHL, 111 MUL.
- FSM states: IDLE, BUSY, DONE.
- IDLE: in_ready=1. When in_valid is high, the bundle is accepted at the edge. For a non-MUL op: result and flags are computed and registered, then state goes to DONE. For MUL: the multiplicand, multiplier, a zeroed 2·WIDTH accumulator and the iteration counter are loaded, then state goes to BUSY.
- BUSY: in_ready=0. Each cycle: if multiplier LSB is 1, add multiplicand into the accumulator; then shift multiplicand left and multiplier right; increment the counter. After exactly WIDTH iterations, register the result and flags, then go to DONE.
- DONE: out_valid=1, in_ready=0. On out_ready, go to IDLE. result and flags stay stable while out_ready is low.
- Arithmetic rules:
  - ADD: result = (a+b) mod 2^WIDTH; carry = bit WIDTH of the sum; ovf = operands share a sign and the result sign differs.
  - SUB: result = a−b; carry = borrow (a < b unsigned); ovf = operand signs differ and the result sign differs from a.
  - AND/OR/XOR: bitwise; carry=0, ovf=0.
  - SLT: result = 1 if a < b signed, else 0; carry=0, ovf=0.
  - SHL: shift amount = b[$clog2(WIDTH)-1:0]; result = a << amount; carry = last bit shifted out (0 when the amount is 0); ovf=0.
  - MUL: unsigned; result = low WIDTH bits of the product; carry = 1 if the high WIDTH bits are nonzero; ovf=0.
  - All ops: zero and neg are derived from the registered result.
- Boundary conditions:
  - in_valid outside IDLE is ignored; no bundle is captured.
  - op and operands are sampled only at acceptance; later changes have no effect.
  - rst_n low in any state (including mid-BUSY) aborts the operation and discards partial results.
- Reset values: state IDLE; result 0; zero, carry, neg, ovf, out_valid all 0. in_ready is 0 while rst_n is low and 1 on the first cycle after release.

## Timing
- Bundle accepted at edge T (in_valid & in_ready).
- Non-MUL: out_valid high from cycle T+1.
- MUL: BUSY occupies WIDTH cycles; out_valid high from cycle T+1+WIDTH.
- Result accepted at edge R (out_valid & out_ready); in_ready high from cycle R+1. Throughput is at most one op per 2 cycles (non-MUL).
- in_ready and out_valid are decoded from the state register only, with no combinational path from in_valid or out_ready.

## Structure
- Shared package alu_pkg:
  - opcode localparams (OP_ADD..OP_MUL);
  - FSM state encoding (ST_IDLE, ST_BUSY, ST_DONE);
  - flag bundle typedef {zero, carry, neg, ovf}.
- Sub-module alu_mul_seq: shift-add multiplier datapath with start/done, parametrised by WIDTH. The top level holds the FSM, the single-cycle op mux, flag logic and output registers.

## Test plan
- ADD a=0xC8 b=0x64 (WIDTH=8) -> result 0x2C, carry 1, ovf 0, zero 0, neg 0; out_valid exactly one cycle after acceptance.
- ADD 0x7F+0x01 -> result 0x80, ovf 1, neg 1, carry 0. SUB 0x05−0x07 -> result 0xFE, carry 1, neg 1. SLT 0xFF,0x01 -> result 0x01.
- SHL a=0x81 b=0x01 -> result 0x02, carry 1. SHL with b=0x08 (amount 0) -> result 0x81, carry 0. XOR 0x5A,0x5A -> result 0x00, zero 1.
- MUL 0x0F×0x11 -> result 0xFF, carry 0, out_valid 9 cycles after acceptance. MUL 0x10×0x10 -> result 0x00, zero 1, carry 1.
- Backpressure: hold out_ready low for 5 cycles after a result while toggling in_valid -> result and flags stable, in_ready 0, no new capture. Raise out_ready -> in_ready 1 on the next cycle.
- Drive rst_n low in BUSY iteration 3 of a MUL -> all outputs 0. After release, in_ready is 1, and a following ADD 0x01+0x02 returns 0x03.
